pipe_stage_reg: RTL and testbench

Parametrised elastic pipeline register for the MIPS datapath: a WIDTH-bit stage register with valid/ready handshake, a one-entry skid buffer so `in_ready` is a registered signal, and a synchronous flush for branch/exception squashing. One instance sits between each pair of pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It sustains one transfer per cycle with one cycle of latency.

---
 rtl/pipe_stage_reg.sv | 115 +++++++++++
 tb/tb_pipe_stage_reg.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register: valid/ready stage with one-entry skid buffer, 1-cycle latency, registered in_ready.
// Optional PIPE_STAGE_PERF_EN adds the saturating stall_count back-pressure counter.
module pipe_stage_reg #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]      stall_count
`endif
);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_ONE,
    S_FULL
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic [WIDTH-1:0] w_main_nxt;
  logic [WIDTH-1:0] w_skid_nxt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             w_up_acc;
  logic             w_dn_acc;

  assign w_up_acc = in_valid && r_in_ready;
  assign w_dn_acc = r_out_valid && out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (flush) begin
      w_state_nxt = S_EMPTY;
      w_main_nxt  = RESET_VAL;
      w_skid_nxt  = RESET_VAL;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_up_acc) begin
            w_state_nxt = S_ONE;
            w_main_nxt  = in_data;
          end
        end
        S_ONE: begin
          if (w_up_acc && w_dn_acc) begin
            w_main_nxt = in_data;
          end else if (w_up_acc) begin
            w_state_nxt = S_FULL;
            w_skid_nxt  = in_data;
          end else if (w_dn_acc) begin
            w_state_nxt = S_EMPTY;
          end
        end
        S_FULL: begin
          // in_ready is low here, so only the skid-to-main move can happen
          if (w_dn_acc) begin
            w_state_nxt = S_ONE;
            w_main_nxt  = r_skid;
          end
        end
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state     <= S_EMPTY;
      r_main      <= RESET_VAL;
      r_skid      <= RESET_VAL;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_main      <= w_main_nxt;
      r_skid      <= w_skid_nxt;
      r_in_ready  <= (w_state_nxt != S_FULL);
      r_out_valid <= (w_state_nxt != S_EMPTY);
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_main;

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] r_stall_cnt;

  // flush never clears the counter; only reset does
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_stall_cnt <= '0;
    end else if (r_out_valid && !out_ready && !flush && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_count = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: a 64-bit and a 1-bit instance share control and are checked
// against a queue model of held items (front = out_data, size<2 = in_ready).
module tb_pipe_stage_reg;
  localparam logic [63:0] RV  = 64'h0123_4567_89AB_CDEF;
  localparam logic [0:0]  RV1 = RV[0:0];

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        nrst      = 1'b0;
  logic        flush     = 1'b0;
  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b0;
  logic [63:0] in_data   = '0;
  logic [0:0]  in_data_b;
  assign in_data_b = in_data[0:0];

  logic        in_ready_a, out_valid_a;
  logic [63:0] out_data_a;
  logic        in_ready_b, out_valid_b;
  logic [0:0]  out_data_b;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_a, stall_b;
`endif

  pipe_stage_reg #(.WIDTH(64), .RESET_VAL(RV)) dut_a (
    .clk(clk), .nrst(nrst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_count(stall_a)
`endif
  );

  pipe_stage_reg #(.WIDTH(1), .RESET_VAL(RV1)) dut_b (
    .clk(clk), .nrst(nrst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data_b),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_count(stall_b)
`endif
  );

  int          total = 0;
  int          bad   = 0;
  int          n_out = 0;
  bit          mon_en = 1'b0;
  logic [63:0] q[$];
  logic [63:0] last_main = RV;
  bit          pend = 1'b0;
  logic [63:0] pend_d = '0;
  logic [31:0] exp_stall = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: compare against the model, then retire what the coming edge consumes.
  always @(negedge clk) begin
    if (mon_en) begin
      logic        v_m, r_m;
      logic [63:0] d_m;
      v_m = (q.size() > 0);
      r_m = (q.size() < 2);
      d_m = v_m ? q[0] : last_main;
      chk("out_valid_a", {63'd0, out_valid_a}, {63'd0, v_m});
      chk("in_ready_a", {63'd0, in_ready_a}, {63'd0, r_m});
      chk("out_data_a", out_data_a, d_m);
      chk("out_valid_b", {63'd0, out_valid_b}, {63'd0, v_m});
      chk("in_ready_b", {63'd0, in_ready_b}, {63'd0, r_m});
      chk("out_data_b", {63'd0, out_data_b}, {63'd0, d_m[0]});
`ifdef PIPE_STAGE_PERF_EN
      chk("stall_a", {32'd0, stall_a}, {32'd0, exp_stall});
      chk("stall_b", {32'd0, stall_b}, {32'd0, exp_stall});
      if (!nrst) exp_stall = '0;
      else if (v_m && !out_ready && !flush && exp_stall != 32'hFFFF_FFFF) exp_stall = exp_stall + 1;
`endif
      if (v_m && out_ready) begin
        last_main = q.pop_front();
        n_out++;
      end
      if (!nrst || flush) begin
        q.delete();
        last_main = RV;
      end
    end
  end

  // One cycle of stimulus; the item accepted at the previous edge is pushed first.
  task automatic step(input logic v, input logic [63:0] d, input logic rdy, input logic fl, input logic rn);
    @(posedge clk);
    #1;
    if (pend) q.push_back(pend_d);
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    flush     = fl;
    nrst      = rn;
    pend      = v && rn && !fl && (q.size() < 2);
    pend_d    = d;
  endtask

  initial begin
    int base;
    step(0, 64'h0, 1, 0, 0);
    mon_en = 1'b1;
    step(0, 64'h0, 1, 0, 0);
    step(0, 64'h0, 1, 0, 1);

    base = n_out;
    step(1, 64'h11, 1, 0, 1);
    step(1, 64'h22, 1, 0, 1);
    step(1, 64'h33, 1, 0, 1);
    repeat (3) step(0, 64'h0, 1, 0, 1);
    chk("stream_count", 64'(n_out - base), 64'd3);

    base = n_out;
    step(1, 64'hA, 0, 0, 1);
    step(1, 64'hB, 0, 0, 1);
    step(1, 64'hC, 0, 0, 1);
    step(1, 64'hC, 0, 0, 1);
    step(1, 64'hC, 1, 0, 1);
    step(1, 64'hC, 1, 0, 1);
    repeat (3) step(0, 64'h0, 1, 0, 1);
    chk("skid_count", 64'(n_out - base), 64'd3);

    base = n_out;
    step(1, 64'hA, 0, 0, 1);
    step(1, 64'hB, 0, 0, 1);
    step(1, 64'hD, 0, 1, 1);
    repeat (3) step(0, 64'h0, 1, 0, 1);
    chk("flush_count", 64'(n_out - base), 64'd0);

    step(1, 64'hA, 0, 0, 1);
    step(1, 64'hB, 0, 0, 1);
    step(0, 64'h0, 0, 1, 0);
    step(0, 64'h0, 1, 0, 1);

    step(1, 64'h5, 0, 0, 1);
    repeat (4) step(0, 64'h0, 0, 0, 1);
    step(0, 64'h0, 0, 1, 1);
    step(0, 64'h0, 1, 0, 1);

    for (int i = 0; i < 10000; i++) begin
      step(($urandom_range(0, 9) < 6), {$urandom, $urandom}, ($urandom_range(0, 9) < 6),
           ($urandom_range(0, 99) < 3), ($urandom_range(0, 199) != 0));
    end

    repeat (4) step(0, 64'h0, 1, 0, 1);
    @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
